// File: rtl/flow_led_pkg.sv
// -----------------------------------------------------------------------------
// flow_led_pkg
// Shared definitions for the flowing-LED controller:
//   mode_e       - pattern mode encodings (UP, DOWN, BOUNCE, BAR)
//   clog2        - bit width needed to index 0..value-1 (never less than 1)
//   speed_limit  - tick count at which a step fires for a given speed code
// -----------------------------------------------------------------------------
package flow_led_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    // Width of a counter or index that must hold 0..value-1. A single-entry
    // range still gets one bit so that no vector ever collapses to zero width.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // A step happens once every 2^speed base ticks, so the tick counter
    // fires when it has reached 2^speed - 1.
    function automatic logic [2:0] speed_limit(input logic [1:0] speed);
        return 3'((4'd1 << speed) - 4'd1);
    endfunction

endpackage

// File: rtl/flow_led_if.sv
// -----------------------------------------------------------------------------
// flow_led_if
// Bundles the control inputs and LED outputs of flow_led_ctrl.
//   flow_stop  - 1 freezes all sequencing state
//   mode       - pattern mode (see flow_led_pkg::mode_e)
//   speed      - one step per 2^speed base ticks
//   flow_led   - active-high LED drive, LED_NUM bits
//   pos        - current LED index
//   step_pulse - one-cycle strobe in the cycle pos takes its new value
// Modports: master drives the controls, slave is the controller itself.
// -----------------------------------------------------------------------------
interface flow_led_if
    import flow_led_pkg::*;
#(
    parameter int LED_NUM = 8
) ();

    localparam int POS_W = clog2(LED_NUM);

    logic               flow_stop;
    logic [1:0]         mode;
    logic [1:0]         speed;
    logic [LED_NUM-1:0] flow_led;
    logic [POS_W-1:0]   pos;
    logic               step_pulse;

    modport master (
        output flow_stop, mode, speed,
        input  flow_led, pos, step_pulse
    );

    modport slave (
        input  flow_stop, mode, speed,
        output flow_led, pos, step_pulse
    );

endinterface

// File: rtl/flow_tick_gen.sv
// -----------------------------------------------------------------------------
// flow_tick_gen
// Timing source for the LED sequencer. A prescaler divides clk_50m down to a
// base tick (one cycle every CLK_DIV), and a tick counter turns base ticks
// into step enables (one every 2^speed ticks). Everything runs on clk_50m;
// no derived clocks.
//   clk_50m  - clock
//   rst      - asynchronous active-high reset
//   enable   - 0 freezes prescaler and tick counter (no phase is lost)
//   speed    - step rate code
//   step_en  - single-cycle enable: the sequencer advances on this edge
// -----------------------------------------------------------------------------
module flow_tick_gen
    import flow_led_pkg::*;
#(
    parameter int CLK_DIV = 25_000_000
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic       step_en
);

    localparam int               PW   = clog2(CLK_DIV);
    localparam logic [PW-1:0]    LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    ticks_q, ticks_d;
    logic          tick;
    logic          step;

    // Next-state for prescaler and tick counter. The speed limit is compared
    // with ">=" so that lowering speed while the count is already past the
    // new limit still produces a step on the very next tick.
    always_comb begin
        tick    = (presc_q == LAST);
        step    = enable && tick && (ticks_q >= speed_limit(speed));
        presc_d = presc_q;
        ticks_d = ticks_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (step) begin
                ticks_d = '0;
            end else if (tick) begin
                ticks_d = ticks_q + 3'd1;
            end
        end
    end

    // State registers; reset restarts the full divide chain so the first
    // step after release lands exactly CLK_DIV*2^speed cycles later.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ticks_q <= '0;
        end else begin
            presc_q <= presc_d;
            ticks_q <= ticks_d;
        end
    end

    assign step_en = step;

endmodule

// File: rtl/flow_led_ctrl.sv
// -----------------------------------------------------------------------------
// flow_led_ctrl
// Flowing-LED pattern generator. A step enable from flow_tick_gen advances
// the LED index pos in one of four modes (UP, DOWN, BOUNCE ping-pong, BAR
// fill), and flow_led is decoded from pos and the current mode.
//   clk_50m - clock
//   rst     - asynchronous active-high reset
//   bus     - flow_led_if slave: flow_stop, mode, speed in;
//             flow_led, pos, step_pulse out
// -----------------------------------------------------------------------------
module flow_led_ctrl
    import flow_led_pkg::*;
#(
    parameter int LED_NUM = 8,
    parameter int CLK_DIV = 25_000_000
) (
    input  logic       clk_50m,
    input  logic       rst,
    flow_led_if.slave  bus
);

    localparam int                POS_W    = clog2(LED_NUM);
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(LED_NUM - 1);

    logic               step_en;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               step_pulse_q;
    logic [LED_NUM-1:0] led;

    flow_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_50m (clk_50m),
        .rst     (rst),
        .enable  (!bus.flow_stop),
        .speed   (bus.speed),
        .step_en (step_en)
    );

    // Position and direction update. Outside BOUNCE the direction simply
    // follows the mode, so switching into BOUNCE carries on the way the
    // pattern was already moving. In BOUNCE the ends turn around without
    // dwelling: the end LED is shown for one step, then we move back inward.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (!bus.flow_stop) begin
            case (bus.mode)
                MODE_UP, MODE_BAR: begin
                    dir_d = 1'b0;
                    if (step_en) begin
                        pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    if (step_en) begin
                        pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
                    end
                end
                default: begin
                    if (step_en) begin
                        if (!dir_q) begin
                            if (pos_q == LAST_POS) begin
                                dir_d = 1'b1;
                                pos_d = LAST_POS - POS_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Sequencer registers. step_pulse is registered alongside pos so the
    // strobe and the new position appear in the same cycle.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            pos_q        <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_en;
        end
    end

    // LED decode: a single lit LED at pos, or in BAR mode every LED from 0
    // up to and including pos.
    always_comb begin
        led = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            if (bus.mode == MODE_BAR) begin
                led[i] = (POS_W'(i) <= pos_q);
            end else begin
                led[i] = (POS_W'(i) == pos_q);
            end
        end
    end

    assign bus.flow_led   = led;
    assign bus.pos        = pos_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flow_led_ctrl
// Directed self-checking bench for flow_led_ctrl with LED_NUM=8, CLK_DIV=4.
// Outputs are sampled on the falling clock edge; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_flow_led_ctrl
    import flow_led_pkg::*;
;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    int   c;
    int   pulses;

    logic [7:0] upLed     [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    int         upPos     [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
    int         bouncePos [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    logic [7:0] bounceLed [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] barLed    [8]  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

    flow_led_if #(.LED_NUM(8)) bus ();

    flow_led_ctrl #(
        .LED_NUM (8),
        .CLK_DIV (4)
    ) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the control inputs.
    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic stop);
        bus.mode      = m;
        bus.speed     = s;
        bus.flow_stop = stop;
    endtask

    // Count falling edges until step_pulse is seen, giving up after limit.
    task automatic waitStep(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.step_pulse && cycles < limit);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(MODE_UP, 2'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_pos",   32'(bus.pos),        32'd0);
        checkOutput("rst_led",   32'(bus.flow_led),   32'h01);
        checkOutput("rst_pulse", 32'(bus.step_pulse), 32'd0);
        rst = 1'b0;

        // UP, speed 0: a step every 4 cycles, wrapping 7 -> 0
        for (int k = 0; k < 8; k++) begin
            waitStep(40, c);
            checkOutput($sformatf("up_gap%0d", k), 32'(c),            32'd4);
            checkOutput($sformatf("up_pos%0d", k), 32'(bus.pos),      32'(upPos[k]));
            checkOutput($sformatf("up_led%0d", k), 32'(bus.flow_led), 32'(upLed[k]));
        end

        // BOUNCE from pos 0 going up: ends lit for a single step
        applyStimulus(MODE_BOUNCE, 2'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            waitStep(40, c);
            checkOutput($sformatf("bnc_gap%0d", k), 32'(c),            32'd4);
            checkOutput($sformatf("bnc_pos%0d", k), 32'(bus.pos),      32'(bouncePos[k]));
            checkOutput($sformatf("bnc_led%0d", k), 32'(bus.flow_led), 32'(bounceLed[k]));
        end

        // Walk on to pos 5 moving down, then reset mid-interval
        for (int k = 0; k < 8; k++) waitStep(40, c);
        checkOutput("bnc_pre_rst_pos", 32'(bus.pos), 32'd5);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_pos",   32'(bus.pos),        32'd0);
        checkOutput("async_rst_led",   32'(bus.flow_led),   32'h01);
        checkOutput("async_rst_pulse", 32'(bus.step_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        waitStep(40, c);
        checkOutput("post_rst_gap", 32'(c),            32'd4);
        checkOutput("post_rst_pos", 32'(bus.pos),      32'd1);
        checkOutput("post_rst_led", 32'(bus.flow_led), 32'h02);
        waitStep(40, c);
        checkOutput("post_rst_pos2", 32'(bus.pos), 32'd2);

        // BAR from reset: fill up to 0xFF then wrap to a single LED
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(MODE_BAR, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("bar_rst_led", 32'(bus.flow_led), 32'h01);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            waitStep(40, c);
            checkOutput($sformatf("bar_gap%0d", k), 32'(c),            32'd4);
            checkOutput($sformatf("bar_led%0d", k), 32'(bus.flow_led), 32'(barLed[k]));
        end

        // Freeze for 10 cycles, one cycle into the interval
        @(negedge clk);
        applyStimulus(MODE_BAR, 2'd0, 1'b1);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.step_pulse) pulses++;
        end
        checkOutput("stop_pulses", 32'(pulses),  32'd0);
        checkOutput("stop_pos",    32'(bus.pos), 32'd0);
        applyStimulus(MODE_BAR, 2'd0, 1'b0);
        waitStep(40, c);
        checkOutput("stop_resume_gap", 32'(c),            32'd3);
        checkOutput("stop_resume_led", 32'(bus.flow_led), 32'h03);

        // DOWN at speed 3 from reset: 32 cycles per step
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(MODE_DOWN, 2'd3, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        waitStep(100, c);
        checkOutput("dn3_gap0", 32'(c),            32'd32);
        checkOutput("dn3_pos0", 32'(bus.pos),      32'd7);
        checkOutput("dn3_led0", 32'(bus.flow_led), 32'h80);
        waitStep(100, c);
        checkOutput("dn3_gap1", 32'(c),            32'd32);
        checkOutput("dn3_pos1", 32'(bus.pos),      32'd6);
        checkOutput("dn3_led1", 32'(bus.flow_led), 32'h40);

        // After 5 ticks, drop to speed 1: count already past limit steps next tick
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.step_pulse) pulses++;
        end
        checkOutput("spd_idle_pulses", 32'(pulses), 32'd0);
        applyStimulus(MODE_DOWN, 2'd1, 1'b0);
        waitStep(40, c);
        checkOutput("spd_gap0", 32'(c),            32'd4);
        checkOutput("spd_pos0", 32'(bus.pos),      32'd5);
        checkOutput("spd_led0", 32'(bus.flow_led), 32'h20);
        waitStep(40, c);
        checkOutput("spd_gap1", 32'(c),       32'd8);
        checkOutput("spd_pos1", 32'(bus.pos), 32'd4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/flow_led_ctrl.md
FLOW_LED_CTRL -- requirements
Module: flow_led_ctrl

Interface
REQ-001 Parameter LED_NUM, default 8, meaning LED count and output width; legal range 2..32.
REQ-002 Parameter CLK_DIV, default 25_000_000, meaning clk_50m cycles per base tick; legal range >= 1.
REQ-003 Port clk_50m, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, meaning the reset; asynchronous, active-high.
REQ-005 Port flow_stop, input, 1, meaning freeze: 1 holds all sequencing state.
REQ-006 Port mode, input, 2, meaning 00 UP (pos increments), 01 DOWN (pos decrements), 10 BOUNCE (ping-pong), 11 BAR (fill-bar, counts up).
REQ-007 Port speed, input, 2, meaning one step per 2^speed base ticks (1, 2, 4 or 8).
REQ-008 Port flow_led, output, LED_NUM, meaning active-high LED drive.
REQ-009 Port pos, output, clog2(LED_NUM), meaning the current LED index.
REQ-010 Port step_pulse, output, 1, meaning a one-cycle strobe in the clock cycle where pos updates.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and wrap, asserting an internal tick for one cycle when the count equals CLK_DIV-1. No derived clocks: every flop is clocked by clk_50m.
REQ-012 Tick counter SHALL count ticks; a step SHALL occur on a tick when the tick count >= 2^speed-1, and the tick count then clears.
REQ-013 A speed change SHALL take effect at the next tick evaluation; a tick count already past the new limit SHALL step on the next tick.
REQ-014 While flow_stop=1, the prescaler, tick counter, pos and direction SHALL hold and step_pulse SHALL be 0.
REQ-015 On release of flow_stop, counting SHALL resume from the held values, with no phase loss.
REQ-016 Step in UP or BAR SHALL set pos = pos+1, wrapping LED_NUM-1 -> 0.
REQ-017 Step in DOWN SHALL set pos = pos-1, wrapping 0 -> LED_NUM-1.
REQ-018 BOUNCE SHALL use a direction flag dir (0=up, 1=down).
REQ-019 In BOUNCE, at pos=LED_NUM-1 with dir=0, the step SHALL set dir=1 and pos=LED_NUM-2.
REQ-020 In BOUNCE, at pos=0 with dir=1, the step SHALL set dir=0 and pos=1.
REQ-021 In BOUNCE, end LEDs SHALL have no dwell: each end is lit for one step only.
REQ-022 Outside BOUNCE, dir SHALL track the mode: 0 in UP and BAR, 1 in DOWN. Entering BOUNCE therefore continues the previous direction.
REQ-023 A mode change SHALL keep pos and SHALL NOT reset the prescaler.
REQ-024 If pos is an end index on entering BOUNCE with the direction pointing outward, the next step SHALL reverse direction per REQ-019/REQ-020.
REQ-025 flow_led SHALL be a combinational decode of pos and mode:
- UP, DOWN, BOUNCE: one-hot, bit[pos]=1.
- BAR: bits[pos:0]=1, bits above pos=0.
REQ-026 pos and step_pulse SHALL be registered. flow_led SHALL reflect the new pos in the same cycle step_pulse is high.

Reset
REQ-027 While rst=1: prescaler=0, tick count=0, pos=0, dir=0, step_pulse=0, flow_led=decode(0, mode). That is 1 in all modes, so bit0 only.
REQ-028 Reset mid-step SHALL abort the step. The first step after deassertion SHALL occur exactly CLK_DIV*2^speed cycles after release.

Structure
REQ-029 Shared package flow_led_pkg SHALL hold:
- the mode encodings MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_BAR;
- the speed-to-limit function;
- the pos-width function clog2.
REQ-030 Sub-module flow_tick_gen SHALL hold:
- the prescaler and speed divider, with parameter CLK_DIV and input speed;
- enable from flow_stop;
- output step_en.
Pos, dir and decode logic SHALL live in flow_led_ctrl.

Verification (LED_NUM=8, CLK_DIV=4)
REQ-031 Reset, mode=UP, speed=0 -> step_pulse every 4 cycles; pos 0,1,...,7,0; flow_led 0x01,0x02,...,0x80,0x01.
REQ-032 mode=BOUNCE from pos=0 -> pos sequence 1..7,6,5..0,1; 0x80 and 0x01 each lit for exactly one step.
REQ-033 mode=BAR, speed=0 -> flow_led 0x01,0x03,...,0xFF, then 0x01 after wrap.
REQ-034 speed=3, mode=DOWN, pos=0 at reset release -> first step at cycle 32 to pos=7, flow_led=0x80; subsequent steps 32 cycles apart.
REQ-035 flow_stop=1 for 10 cycles mid-interval -> pos frozen, no step_pulse; after release the next step lands 10 cycles later than the unstopped schedule.
REQ-036 rst pulse at pos=5 in BOUNCE with dir=1 -> pos=0, dir=0, flow_led=0x01 immediately (async); first step 4 cycles after release, to pos=1.
